// File: rtl/seg7_decoder.sv
// seg7_decoder: captures an active-low seven-segment pattern on seg_strobe,
// decodes it to a hex digit and presents it on a valid/ready output.
// Pattern bit order: seg_in[6]=a ... seg_in[0]=g.
//
// Optional feature macro: SEG7_STABLE_FILTER_EN
//   defined   : the capture passes through a SETTLE state. The pattern must be
//               seen unchanged for STABLE_CYCLES cycles before it is decoded.
//               After SETTLE_TIMEOUT cycles in SETTLE an error result is forced.
//   undefined : a strobe in IDLE decodes seg_in directly into OUTPUT. The
//               parameters are accepted but have no effect.
module seg7_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int SETTLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_strobe,
  output logic [3:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_err,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // Blank display: every segment off, all bits high because inputs are active-low.
  localparam logic [6:0] SEG_BLANK_C = 7'h7F;

  state_e     state_q;
  logic [3:0] dout_q;
  logic       dout_err_q;
  logic       dout_valid_q;
  logic       busy_q;
  logic       overrun_q;

  // Maps a pattern to {err, value}; anything outside the 16 codes is an error with value 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h01:   res = {1'b0, 4'h0};
      7'h4F:   res = {1'b0, 4'h1};
      7'h12:   res = {1'b0, 4'h2};
      7'h06:   res = {1'b0, 4'h3};
      7'h4C:   res = {1'b0, 4'h4};
      7'h24:   res = {1'b0, 4'h5};
      7'h20:   res = {1'b0, 4'h6};
      7'h0F:   res = {1'b0, 4'h7};
      7'h00:   res = {1'b0, 4'h8};
      7'h04:   res = {1'b0, 4'h9};
      7'h08:   res = {1'b0, 4'hA};
      7'h60:   res = {1'b0, 4'hB};
      7'h31:   res = {1'b0, 4'hC};
      7'h42:   res = {1'b0, 4'hD};
      7'h30:   res = {1'b0, 4'hE};
      7'h38:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

`ifdef SEG7_STABLE_FILTER_EN

  localparam logic [3:0] STABLE_C  = 4'(STABLE_CYCLES);
  localparam logic [7:0] TIMEOUT_C = 8'(SETTLE_TIMEOUT);

  logic [6:0] cap_q;
  logic [3:0] match_cnt_q;
  logic [7:0] to_cnt_q;
  logic [3:0] match_cnt_d;
  logic [7:0] to_cnt_d;
  logic       same_s;
  logic       stable_hit_s;
  logic       timeout_hit_s;
  logic [4:0] cap_dec_s;

  // Incremented counters and the stable/timeout decisions for the current SETTLE cycle.
  always_comb begin
    match_cnt_d   = match_cnt_q + 4'd1;
    to_cnt_d      = to_cnt_q + 8'd1;
    same_s        = (seg_in == cap_q);
    stable_hit_s  = same_s && (match_cnt_d == STABLE_C);
    timeout_hit_s = (to_cnt_d == TIMEOUT_C);
    cap_dec_s     = seg_decode(cap_q);
  end

  // Main FSM: capture, settle filtering, result hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cap_q        <= SEG_BLANK_C;
      match_cnt_q  <= 4'd0;
      to_cnt_q     <= 8'd0;
      dout_q       <= 4'h0;
      dout_err_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seg_strobe) begin
            cap_q       <= seg_in;
            match_cnt_q <= 4'd0;
            to_cnt_q    <= 8'd0;
            busy_q      <= 1'b1;
            state_q     <= ST_SETTLE;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          // A stable decode takes precedence over a timeout landing in the same cycle.
          if (stable_hit_s) begin
            dout_q       <= cap_dec_s[3:0];
            dout_err_q   <= cap_dec_s[4];
            dout_valid_q <= 1'b1;
            state_q      <= ST_OUTPUT;
          end else if (timeout_hit_s) begin
            dout_q       <= 4'h0;
            dout_err_q   <= 1'b1;
            dout_valid_q <= 1'b1;
            state_q      <= ST_OUTPUT;
          end else if (same_s) begin
            match_cnt_q <= match_cnt_d;
            to_cnt_q    <= to_cnt_d;
          end else begin
            // Pattern moved: restart the stability window on the new value.
            cap_q       <= seg_in;
            match_cnt_q <= 4'd0;
            to_cnt_q    <= to_cnt_d;
          end
        end
        ST_OUTPUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            dout_q       <= 4'h0;
            dout_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            dout_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

`else

  // Parameters are only range-checked here; an out-of-range value yields this marker scope.
  if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > 15) ||
      (SETTLE_TIMEOUT < 2) || (SETTLE_TIMEOUT > 255)) begin : g_cfg_out_of_range
  end

  logic [4:0] in_dec_s;

  // Direct decode of the live input pattern.
  always_comb begin
    in_dec_s = seg_decode(seg_in);
  end

  // Main FSM: decode on strobe, hold result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dout_q       <= 4'h0;
      dout_err_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seg_strobe) begin
            dout_q       <= in_dec_s[3:0];
            dout_err_q   <= in_dec_s[4];
            dout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_OUTPUT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_OUTPUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            dout_q       <= 4'h0;
            dout_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            dout_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

`endif

  // Sticky overrun: any strobe while busy is flagged until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (seg_strobe && busy_q) begin
      overrun_q <= 1'b1;
    end else begin
      overrun_q <= overrun_q;
    end
  end

  assign dout       = dout_q;
  assign dout_err   = dout_err_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder with a result scoreboard.
// Follows the SEG7_STABLE_FILTER_EN setting of the build.
module tb_seg7_decoder;

  localparam int STABLE_CYCLES  = 4;
  localparam int SETTLE_TIMEOUT = 64;
`ifdef SEG7_STABLE_FILTER_EN
  localparam int LAT = STABLE_CYCLES + 1;
`else
  localparam int LAT = 1;
`endif
  localparam int WAIT_MAX = SETTLE_TIMEOUT + 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       seg_strobe = 1'b0;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_err;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  logic [4:0] sb_q[$];

  // Table indexed by the hex value it must decode to.
  logic [6:0] pat_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg7_decoder #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SETTLE_TIMEOUT(SETTLE_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .seg_strobe(seg_strobe),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_err  (dout_err),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the presented result against the oldest scoreboard entry and retire it.
  task automatic sb_pop_check(input string tag);
    logic [4:0] exp;
    check_eq({tag, "_sb_size"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check_eq({tag, "_result"}, {dout_err, dout}, exp);
    end
  endtask

  // Strobe one pattern with ready held high and check latency, result and return to idle.
  task automatic run_xfer(input logic [6:0] pat, input logic [4:0] exp, input string tag);
    int n;
    seg_in     = pat;
    seg_strobe = 1'b1;
    dout_ready = 1'b1;
    sb_q.push_back(exp);
    tick();
    seg_strobe = 1'b0;
    n = 1;
    check_eq({tag, "_busy"}, busy, 1);
    while (!dout_valid && n < WAIT_MAX) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, n, LAT);
    sb_pop_check(tag);
    tick();
    check_eq({tag, "_valid_drop"}, dout_valid, 0);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_dout", dout, 0);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_err", dout_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    tick();

    // All 16 codes.
    for (int i = 0; i < 16; i++) begin
      run_xfer(pat_tab[i], {1'b0, 4'(i)}, $sformatf("hex%0d", i));
    end
    // Invalid patterns, including blank.
    run_xfer(7'h7F, 5'h10, "blank");
    run_xfer(7'h7E, 5'h10, "bad7E");
    run_xfer(7'h12, 5'h02, "two_again");

`ifdef SEG7_STABLE_FILTER_EN
    // Pattern toggling every cycle never settles: timeout forces an error result.
    seg_in     = 7'h01;
    seg_strobe = 1'b1;
    dout_ready = 1'b1;
    sb_q.push_back(5'h10);
    tick();
    seg_strobe = 1'b0;
    n = 1;
    while (!dout_valid && n < WAIT_MAX) begin
      seg_in = (seg_in == 7'h01) ? 7'h4F : 7'h01;
      tick();
      n++;
    end
    check_eq("timeout_lat", n, SETTLE_TIMEOUT + 1);
    sb_pop_check("timeout");
    tick();
    check_eq("timeout_idle", busy, 0);
`endif

    // Result held while not accepted; strobe in OUTPUT is ignored and flags overrun.
    seg_in     = 7'h38;
    seg_strobe = 1'b1;
    dout_ready = 1'b0;
    sb_q.push_back(5'h0F);
    tick();
    seg_strobe = 1'b0;
    n = 1;
    while (!dout_valid && n < WAIT_MAX) begin
      tick();
      n++;
    end
    check_eq("hold_lat", n, LAT);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("hold_valid%0d", k), dout_valid, 1);
      if (sb_q.size() > 0) check_eq($sformatf("hold_res%0d", k), {dout_err, dout}, sb_q[0]);
      else check_eq("hold_sb_size", sb_q.size(), 1);
      seg_strobe = (k == 3);
      if (k == 3) seg_in = 7'h01;
      tick();
    end
    seg_strobe = 1'b0;
    check_eq("overrun_set", overrun, 1);
    sb_pop_check("hold");
    dout_ready = 1'b1;
    tick();
    check_eq("hold_release_valid", dout_valid, 0);
    check_eq("hold_release_busy", busy, 0);
    check_eq("overrun_sticky", overrun, 1);

    // Reset in mid-transfer discards the pending result and clears overrun.
    seg_in     = 7'h12;
    seg_strobe = 1'b1;
    dout_ready = 1'b0;
    tick();
    seg_strobe = 1'b0;
    tick();
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", dout_valid, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    check_eq("mid_rst_err", dout_err, 0);
    tick();
    run_xfer(7'h12, 5'h02, "post_rst");
    check_eq("post_rst_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required before decode (range 1..15).
REQ-002 SHALL have parameter SETTLE_TIMEOUT, default 64, meaning the maximum number of SETTLE cycles before an error result is forced (range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seg_in, input, 7 bits: active-low segment pattern, seg_in[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
REQ-006 SHALL have port seg_strobe, input, 1 bit: capture request, sampled only in IDLE.
REQ-007 SHALL have port dout, output, 4 bits: decoded hex value.
REQ-008 SHALL have port dout_valid, output, 1 bit: result available.
REQ-009 SHALL have port dout_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port dout_err, output, 1 bit: the pattern is not one of the 16 codes, or the timeout expired; qualified by dout_valid.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when seg_strobe is high while busy.

Function
REQ-013 SHALL implement a state machine with states IDLE, SETTLE and OUTPUT.
REQ-014 In IDLE with seg_strobe=1, SHALL capture seg_in into cap_reg, clear the match and timeout counters, and move to SETTLE.
REQ-015 In SETTLE, each cycle where seg_in==cap_reg SHALL increment the match count; a mismatch SHALL recapture seg_in and zero the match count.
REQ-016 When the match count reaches STABLE_CYCLES, the block SHALL decode cap_reg and enter OUTPUT.
REQ-017 With constant seg_in and seg_strobe in cycle 0, dout_valid SHALL first be high in cycle STABLE_CYCLES+1.
REQ-018 When the timeout counter reaches SETTLE_TIMEOUT, the block SHALL enter OUTPUT with dout=0 and dout_err=1; if the stable condition and the timeout occur in the same cycle, the stable decode SHALL win.
REQ-019 Decode table (hex pattern->value): 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 04->9, 08->A, 60->B, 31->C, 42->D, 30->E, 38->F.
REQ-020 Any other pattern, including 7F (blank), SHALL produce dout=0 and dout_err=1.
REQ-021 In OUTPUT, dout_valid SHALL be 1 and dout/dout_err SHALL be held stable until dout_ready=1.
REQ-022 On dout_valid&&dout_ready, the block SHALL return to IDLE, and dout_valid SHALL be 0 in the next cycle.
REQ-023 A new capture SHALL be possible no earlier than the cycle after the return to IDLE.
REQ-024 dout_ready while not in OUTPUT SHALL be ignored.
REQ-025 seg_strobe in SETTLE or OUTPUT SHALL be ignored for capture and SHALL set overrun.
REQ-026 overrun SHALL be cleared only by rst.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, dout=0, dout_valid=0, dout_err=0, busy=0, overrun=0, and all counters and cap_reg cleared (cap_reg=7F).
REQ-028 rst SHALL take priority over every other input, including mid-SETTLE and during OUTPUT while dout_ready=0; any pending result is discarded.

Configuration
REQ-029 With macro SEG7_STABLE_FILTER_EN defined, SHALL implement SETTLE, STABLE_CYCLES and SETTLE_TIMEOUT as specified above.
REQ-030 Without SEG7_STABLE_FILTER_EN, the block SHALL omit SETTLE and the counters; IDLE with seg_strobe SHALL decode seg_in directly into OUTPUT, so dout_valid is high in cycle 1.
REQ-031 Without SEG7_STABLE_FILTER_EN, the parameters SHALL be accepted but unused, and all other requirements SHALL still hold.

Verification
REQ-032 Filter on, STABLE_CYCLES=4: seg_in=12, strobe in cycle 0, dout_ready=1 -> dout_valid in cycle 5, dout=2, dout_err=0, IDLE in cycle 6.
REQ-033 Filter on: seg_in=7F steady, strobe -> dout=0, dout_err=1 after STABLE_CYCLES+1 cycles.
REQ-034 Filter on: seg_in toggles between 01 and 4F every cycle after the strobe -> at the SETTLE_TIMEOUT cycle, dout_valid=1, dout_err=1, dout=0.
REQ-035 seg_in=38, dout_ready=0 for 10 cycles, strobe pulsed during OUTPUT -> dout=F held, overrun=1; dout_ready=1 -> IDLE, overrun stays 1.
REQ-036 rst asserted during SETTLE with the count at 2 -> next cycle busy=0, dout_valid=0, overrun=0; a fresh strobe then decodes normally.
REQ-037 Filter off: all 16 table patterns, strobe in cycle 0 -> dout_valid in cycle 1 with the matching dout and dout_err=0.
